// File: rtl/tdm_mux8to1_tx_pkg.sv
// Shared definitions for the TDM 8:1 transmitter and its matching 1:8 receiver.
// State encodings, frame constants and the slot-counter width helper.
package tdm_mux8to1_tx_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    localparam int unsigned NCH          = 8;
    localparam int unsigned SEL_W        = 3;
    localparam int unsigned PAR_SLOT_IDX = 8;

    // Slot counter needs at least one bit even when every cycle ends a slot.
    function automatic int unsigned cnt_width(input int unsigned slot_cyc);
        return (slot_cyc > 1) ? $clog2(slot_cyc) : 1;
    endfunction

endpackage

// File: rtl/tdm_mux8to1_tx_mux8to1.sv
// Combinational 8:1 bit select used by the TDM transmitter to pick the bit for a slot.
module tdm_mux8to1_tx_mux8to1
    import tdm_mux8to1_tx_pkg::*;
(
    input  logic [NCH-1:0]   data,
    input  logic [SEL_W-1:0] sel,
    output logic             dout
);

    assign dout = data[sel];

endmodule

// File: rtl/tdm_mux8to1_tx.sv
// Time-division 8:1 transmitter: captures a parallel word via valid/ready and sends it LSB first,
// one bit per slot. Define PARITY_EN to append a ninth even-parity slot to every frame.
module tdm_mux8to1_tx
    import tdm_mux8to1_tx_pkg::tx_state_e, tdm_mux8to1_tx_pkg::TX_IDLE,
           tdm_mux8to1_tx_pkg::TX_SEND, tdm_mux8to1_tx_pkg::cnt_width;
#(
    parameter int unsigned NCH      = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned SLOT_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic [SEL_W-1:0] sel_out,
    output logic             frame_start,
    output logic             busy,
    output logic             par_slot
);

    localparam int unsigned      CNT_W    = cnt_width(SLOT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

    if (NCH != tdm_mux8to1_tx_pkg::NCH) begin : g_bad_nch
        $error("tdm_mux8to1_tx: NCH must be 8");
    end
    if (SEL_W != $clog2(NCH)) begin : g_bad_sel_w
        $error("tdm_mux8to1_tx: SEL_W must equal clog2(NCH)");
    end
    if (SLOT_CYC < 1 || SLOT_CYC > 16) begin : g_bad_slot_cyc
        $error("tdm_mux8to1_tx: SLOT_CYC must be in 1..16");
    end

    tx_state_e        state_q, state_d;
    logic [7:0]       cap_q, cap_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_q, ser_d;
    logic             fs_q, fs_d;
    logic             last_slot;
    logic             slot_end;
    logic             accept;
    logic [7:0]       mux_data;
    logic [SEL_W-1:0] mux_sel;
    logic             mux_bit;

`ifdef PARITY_EN
    logic par_q, par_d;
    assign last_slot = par_q;
    assign par_slot  = par_q;
`else
    assign last_slot = (sel_q == SEL_LAST);
    assign par_slot  = 1'b0;
`endif

    assign slot_end = (cnt_q == CNT_LAST);
    assign in_ready = (state_q == TX_IDLE) || (slot_end && last_slot);
    assign accept   = in_valid && in_ready;

    // A new word starts straight from in_data since cap is only loaded at this edge.
    assign mux_data = accept ? in_data : cap_q;
    assign mux_sel  = accept ? '0 : sel_q + SEL_W'(1);

    tdm_mux8to1_tx_mux8to1 u_mux (
        .data (mux_data),
        .sel  (mux_sel),
        .dout (mux_bit)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        fs_d    = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            TX_IDLE: ;
            TX_SEND: begin
                if (!slot_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (last_slot) begin
                        state_d = TX_IDLE;
                        sel_d   = '0;
                        ser_d   = 1'b0;
`ifdef PARITY_EN
                        par_d   = 1'b0;
                    end else if (sel_q == SEL_LAST) begin
                        par_d   = 1'b1;
                        ser_d   = ^cap_q;
`endif
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                        ser_d   = mux_bit;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Accept overrides the end-of-frame return so back-to-back frames stay gapless.
        if (accept) begin
            state_d = TX_SEND;
            cap_d   = in_data;
            sel_d   = '0;
            cnt_d   = '0;
            ser_d   = mux_bit;
            fs_d    = 1'b1;
`ifdef PARITY_EN
            par_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cap_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            fs_q    <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            fs_q    <= fs_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign busy        = (state_q == TX_SEND);
    assign ser_out     = ser_q;
    assign sel_out     = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tdm_mux8to1_tx.sv
// Directed bench for tdm_mux8to1_tx: cycle table for single and back-to-back frames, plus
// SLOT_CYC=3, hold/reset, parity and loopback sequences.
module tb_tdm_mux8to1_tx;

`ifdef PARITY_EN
    localparam int NSLOT = 9;
`else
    localparam int NSLOT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d1, d3;
    logic       v1, v3;
    logic       r1, s1, fs1, b1, p1;
    logic       r3, s3, fs3, b3, p3;
    logic [2:0] sel1, sel3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_mux8to1_tx #(.NCH(8), .SEL_W(3), .SLOT_CYC(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (d1),
        .in_valid    (v1),
        .in_ready    (r1),
        .ser_out     (s1),
        .sel_out     (sel1),
        .frame_start (fs1),
        .busy        (b1),
        .par_slot    (p1)
    );

    tdm_mux8to1_tx #(.NCH(8), .SEL_W(3), .SLOT_CYC(3)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (d3),
        .in_valid    (v3),
        .in_ready    (r3),
        .ser_out     (s3),
        .sel_out     (sel3),
        .frame_start (fs3),
        .busy        (b3),
        .par_slot    (p3)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ser;
        logic [2:0] sel;
        logic       fs;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t tv [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ser1"}, 32'(s1), 0);
        chk({tag, " sel1"}, 32'(sel1), 0);
        chk({tag, " fs1"}, 32'(fs1), 0);
        chk({tag, " busy1"}, 32'(b1), 0);
        chk({tag, " par1"}, 32'(p1), 0);
        chk({tag, " rdy1"}, 32'(r1), 1);
        chk({tag, " ser3"}, 32'(s3), 0);
        chk({tag, " busy3"}, 32'(b3), 0);
        chk({tag, " rdy3"}, 32'(r3), 1);
    endtask

    initial begin
        logic [7:0] word;
        logic [7:0] rb;
        int         slot;
        logic [7:0] pw [2];
        logic       pexp [2];

        // v, d, ser, sel, fs, busy, rdy -- A5 single frame, then 0F/F0 back-to-back
        tv[0]  = '{1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 8'h00, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 8'h0F, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tv[10] = '{1'b1, 8'hF0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[11] = '{1'b1, 8'hF0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
        tv[12] = '{1'b1, 8'hF0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        tv[13] = '{1'b1, 8'hF0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
        tv[14] = '{1'b1, 8'hF0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        tv[15] = '{1'b1, 8'hF0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0};
        tv[16] = '{1'b1, 8'hF0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0};
        tv[17] = '{1'b1, 8'hF0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b1};
        tv[18] = '{1'b1, 8'hF0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[19] = '{1'b1, 8'hF0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
        tv[20] = '{1'b1, 8'hF0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        tv[21] = '{1'b1, 8'hF0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        tv[22] = '{1'b1, 8'hF0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
        tv[23] = '{1'b1, 8'hF0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0};
        tv[24] = '{1'b1, 8'hF0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0};
        tv[25] = '{1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1};
        tv[26] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        v1 = 1'b0; d1 = 8'h00;
        v3 = 1'b0; d3 = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef PARITY_EN
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            v1 = tv[i].v;
            d1 = tv[i].d;
            #1;
            chk($sformatf("row%0d ser", i), 32'(s1), 32'(tv[i].ser));
            chk($sformatf("row%0d sel", i), 32'(sel1), 32'(tv[i].sel));
            chk($sformatf("row%0d frame_start", i), 32'(fs1), 32'(tv[i].fs));
            chk($sformatf("row%0d busy", i), 32'(b1), 32'(tv[i].busy));
            chk($sformatf("row%0d in_ready", i), 32'(r1), 32'(tv[i].rdy));
            chk($sformatf("row%0d par_slot", i), 32'(p1), 0);
        end
`else
        pw[0] = 8'h07; pexp[0] = 1'b1;
        pw[1] = 8'h03; pexp[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            v1 = 1'b1;
            d1 = pw[k];
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                if (c == 1) v1 = 1'b0;
                #1;
                chk($sformatf("par%0d c%0d par_slot", k, c), 32'(p1), 32'(c == 9));
                chk($sformatf("par%0d c%0d in_ready", k, c), 32'(r1), 32'(c == 9));
                if (c == 9) begin
                    chk($sformatf("par%0d ser", k), 32'(s1), 32'(pexp[k]));
                    chk($sformatf("par%0d sel", k), 32'(sel1), 7);
                end
            end
        end
        @(negedge clk);
        #1;
        chk("par end busy", 32'(b1), 0);
`endif

        // SLOT_CYC=3 instance, 8'h81: each slot held three cycles
        word = 8'h81;
        @(negedge clk);
        v3 = 1'b1;
        d3 = word;
        #1;
        chk("slot3 accept ready", 32'(r3), 1);
        for (int c = 1; c <= NSLOT * 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                v3 = 1'b0;
                d3 = 8'h00;
            end
            #1;
            slot = (c - 1) / 3;
            chk($sformatf("slot3 c%0d ser", c), 32'(s3), (slot == 8) ? 32'(^word) : 32'(word[slot]));
            chk($sformatf("slot3 c%0d sel", c), 32'(sel3), (slot > 7) ? 7 : 32'(slot));
            chk($sformatf("slot3 c%0d in_ready", c), 32'(r3), 32'(c == NSLOT * 3));
            chk($sformatf("slot3 c%0d frame_start", c), 32'(fs3), 32'(c == 1));
            chk($sformatf("slot3 c%0d busy", c), 32'(b3), 1);
        end
        @(negedge clk);
        #1;
        chk("slot3 end busy", 32'(b3), 0);

        // Hold in_data change mid-frame, then reset during slot 5
        @(negedge clk);
        v1 = 1'b1;
        d1 = 8'h00;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) v1 = 1'b0;
            if (c == 4) d1 = 8'hFF;
            #1;
            chk($sformatf("hold c%0d ser", c), 32'(s1), 0);
            chk($sformatf("hold c%0d sel", c), 32'(sel1), 32'(c - 1));
        end
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v1 = 1'b1;
        d1 = 8'hC3;
        @(negedge clk);
        v1 = 1'b0;
        #1;
        chk("after reset frame_start", 32'(fs1), 1);
        chk("after reset sel0", 32'(sel1), 0);
        chk("after reset ser0", 32'(s1), 1);
        @(negedge clk);
        #1;
        chk("after reset sel1", 32'(sel1), 1);
        chk("after reset ser1", 32'(s1), 1);
        @(negedge clk);
        #1;
        chk("after reset sel2", 32'(sel1), 2);
        chk("after reset ser2", 32'(s1), 0);
        repeat (NSLOT) @(negedge clk);
        #1;
        chk("after reset idle", 32'(b1), 0);

        // Loopback through a behavioural 1:8 demux plus latch
        for (int k = 0; k < 6; k++) begin
            word = 8'($urandom);
            @(negedge clk);
            v1 = 1'b1;
            d1 = word;
            rb = 8'h00;
            for (int c = 1; c <= NSLOT; c++) begin
                @(negedge clk);
                if (c == 1) v1 = 1'b0;
                #1;
                if (p1) chk($sformatf("loop%0d parity", k), 32'(s1), 32'(^word));
                else rb[sel1] = s1;
            end
            chk($sformatf("loop%0d word", k), 32'(rb), 32'(word));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
